// File: rtl/audio_tx_pkg.sv
// Shared types for the stereo DAC serializer: sample format, channel FSM
// states and a counter-width helper.
package audio_tx_pkg;

  typedef enum logic {FMT_I2S = 1'b0, FMT_LJ = 1'b1} fmt_t;

  typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  // Width of a counter that must count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// BCLK divider with next-edge strobes, plus an MCLK divider that exists only
// when AUDIO_TX_MCLK_EN is defined (mclk is tied low otherwise).
module audio_clk_gen
  import audio_tx_pkg::*;
#(
  parameter int BCLK_HALF = 4,
  parameter int MCLK_HALF = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic bclk_fall,
  output logic bclk_rise,
  output logic mclk
);

  localparam int HW = cnt_w(BCLK_HALF);
  localparam logic [HW-1:0] HALF_LAST = HW'(BCLK_HALF - 1);

  logic [HW-1:0] half_cnt;
  logic          phase;
  logic          half_end;

  // Strobes fire in the cycle before the edge they announce, so logic keyed
  // to bclk_fall updates on the same clk edge that drives bclk low.
  assign half_end  = (half_cnt == HALF_LAST);
  assign bclk_fall = half_end && phase;
  assign bclk_rise = half_end && !phase;

  // The phase runs freely so a fall strobe is available while idle; bclk
  // itself only follows the phase while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      bclk     <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      phase    <= !phase;
      bclk     <= en && !phase;
    end else begin
      half_cnt <= half_cnt + 1'b1;
      bclk     <= bclk && en;
    end
  end

`ifdef AUDIO_TX_MCLK_EN
  localparam int MW = cnt_w(MCLK_HALF);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);

  logic [MW-1:0] mclk_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt == MCLK_LAST) begin
      mclk_cnt <= '0;
      mclk     <= !mclk;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end
`else
  localparam int unused_mclk_half = MCLK_HALF;
  assign mclk = 1'b0;
`endif

endmodule

// File: rtl/audio_serial_tx.sv
// Stereo I2S / left-justified DAC serializer with a one-pair holding register.
// Define AUDIO_TX_MCLK_EN to generate mclk on-chip.
module audio_serial_tx
  import audio_tx_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 4,
  parameter int MCLK_HALF = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                dac_lr_ck,
  output logic                dac_dat,
  output logic                bclk,
  output logic                mclk,
  output logic                underrun
);

  localparam int CW = $clog2(SLOT_W);
  localparam int SW = SAMPLE_W + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(SLOT_W - 1);

  state_t              state;
  fmt_t                fmt;
  logic [CW-1:0]       bit_cnt;
  logic [SW-1:0]       shift;
  logic [SAMPLE_W-1:0] right_buf;
  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic                hold_full;
  logic                hold_full_next;
  logic                accept;
  logic                start_frame;
  logic                run;
  logic                bclk_fall;
  logic                unused_bclk_rise;

  // The extra shifter bit places the MSB one BCLK late in I2S, or leaves a
  // trailing zero in left-justified mode.
  function automatic logic [SW-1:0] frame_slot(input fmt_t f, input logic [SAMPLE_W-1:0] s);
    return (f == FMT_LJ) ? {s, 1'b0} : {1'b0, s};
  endfunction

  assign run         = (state != IDLE);
  assign accept      = s_valid && s_ready;
  assign start_frame = bclk_fall && en &&
                       ((state == IDLE) || ((state == RIGHT) && (bit_cnt == BIT_LAST)));
  assign hold_full_next = accept || (hold_full && !start_frame);

  audio_clk_gen #(
    .BCLK_HALF(BCLK_HALF),
    .MCLK_HALF(MCLK_HALF)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .bclk     (bclk),
    .bclk_fall(bclk_fall),
    .bclk_rise(unused_bclk_rise),
    .mclk     (mclk)
  );

  // A load and a handshake in the same cycle: the load reads the old pair
  // while the handshake writes the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      s_ready   <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (accept) begin
        hold_l <= s_left;
        hold_r <= s_right;
      end
      hold_full <= hold_full_next;
      s_ready   <= !hold_full_next;
    end
  end

  // Each fall strobe emits the bit selected on the previous one, so serial
  // data trails the channel state by one BCLK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fmt       <= FMT_I2S;
      bit_cnt   <= '0;
      shift     <= '0;
      right_buf <= '0;
      dac_dat   <= 1'b0;
      dac_lr_ck <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          dac_dat   <= 1'b0;
          dac_lr_ck <= !mode;
          if (start_frame) begin
            state   <= LEFT;
            bit_cnt <= '0;
          end
        end
        LEFT, RIGHT: begin
          if (bclk_fall) begin
            dac_dat   <= shift[SW-1];
            dac_lr_ck <= ((state == LEFT) == (fmt == FMT_LJ));
            shift     <= {shift[SW-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (state == LEFT) begin
                state <= RIGHT;
                shift <= frame_slot(fmt, right_buf);
              end else begin
                state <= en ? LEFT : IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (start_frame) begin
        fmt       <= fmt_t'(mode);
        shift     <= hold_full ? frame_slot(fmt_t'(mode), hold_l) : '0;
        right_buf <= hold_full ? hold_r : '0;
        underrun  <= !hold_full;
      end
    end
  end

endmodule

// File: tb/tb_audio_serial_tx.sv
// Scoreboard bench for audio_serial_tx: pushed pairs queue their expected
// frame; a monitor decodes the serial stream and compares.
module tb_audio_serial_tx;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int BCLK_HALF  = 4;
  localparam int MCLK_HALF  = 10;
  localparam int FRAME_CLKS = 2 * SLOT_W * 2 * BCLK_HALF;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                en = 1'b0;
  logic                mode = 1'b0;
  logic                s_valid = 1'b0;
  logic [SAMPLE_W-1:0] s_left = '0;
  logic [SAMPLE_W-1:0] s_right = '0;
  logic                s_ready;
  logic                dac_lr_ck;
  logic                dac_dat;
  logic                bclk;
  logic                mclk;
  logic                underrun;

  always #2 clk = ~clk;

  audio_serial_tx #(
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W),
    .BCLK_HALF(BCLK_HALF),
    .MCLK_HALF(MCLK_HALF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .dac_lr_ck(dac_lr_ck),
    .dac_dat  (dac_dat),
    .bclk     (bclk),
    .mclk     (mclk),
    .underrun (underrun)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  logic [2*SAMPLE_W-1:0] exp_q[$];
  int accept_cycles[$];
  int underrun_cycles[$];

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic failNote(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting, got none, expected event", name);
  endtask

  // Monitor: slot boundaries are LRCK changes seen at rising bclk.
  logic                prev_bclk = 1'b0;
  logic                prev_lr = 1'b0;
  logic                slot_active = 1'b0;
  logic                in_left = 1'b0;
  logic                have_left = 1'b0;
  logic [SAMPLE_W:0]   slot_bits = '0;
  logic [SAMPLE_W-1:0] got_l = '0;
  int                  slot_cnt = 0;
  int                  left_starts = 0;
  int                  last_left = -1;
  int                  zero_frames = 0;

  task automatic finishSlot();
    logic [SAMPLE_W-1:0]   samp;
    logic                  pad;
    logic [2*SAMPLE_W-1:0] frame;
    samp = mode ? slot_bits[SAMPLE_W:1] : slot_bits[SAMPLE_W-1:0];
    pad  = mode ? slot_bits[0] : slot_bits[SAMPLE_W];
    checkOutput("slot_pad", {31'd0, pad}, 32'd0);
    if (in_left) begin
      got_l = samp;
      have_left = 1'b1;
    end else if (have_left) begin
      have_left = 1'b0;
      frame = {got_l, samp};
      if (frame == '0) zero_frames++;
      else if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL frame_unexpected: got %0h, expected no frame", frame);
      end else checkOutput("frame", frame, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      slot_active = 1'b0;
      have_left   = 1'b0;
      prev_bclk   = 1'b0;
      prev_lr     = !mode;
      last_left   = -1;
    end else begin
      if (underrun) underrun_cycles.push_back(cycle);
      if (bclk && !prev_bclk) begin
        if (dac_lr_ck !== prev_lr) begin
          slot_active = 1'b1;
          slot_cnt    = 0;
          slot_bits   = '0;
          in_left     = (dac_lr_ck == mode);
          if (in_left) begin
            left_starts++;
            if (last_left >= 0 && (cycle - last_left) <= 600)
              checkOutput("frame_len", cycle - last_left, FRAME_CLKS);
            last_left = cycle;
          end
        end
        prev_lr = dac_lr_ck;
        if (slot_active && slot_cnt <= SAMPLE_W) begin
          slot_bits[SAMPLE_W - slot_cnt] = dac_dat;
          slot_cnt++;
          if (slot_cnt == SAMPLE_W + 1) finishSlot();
        end
      end
      prev_bclk = bclk;
    end
  end

  // Holds s_valid until accepted; the expected frame is queued on transfer.
  task automatic applyStimulus(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    int waited;
    waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    while (!s_ready && waited < 3 * FRAME_CLKS) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) failNote("push_accept");
    else begin
      @(posedge clk);
      #1;
      exp_q.push_back({l, r});
      accept_cycles.push_back(cycle);
    end
    s_valid = 1'b0;
  endtask

  task automatic waitLeftStart();
    int target;
    int waited;
    target = left_starts + 1;
    waited = 0;
    while (left_starts < target && waited < 2 * FRAME_CLKS) begin
      @(negedge clk);
      waited++;
    end
    if (left_starts < target) failNote("left_start");
  endtask

  task automatic waitReady();
    int waited;
    waited = 0;
    while (!s_ready && waited < 2 * FRAME_CLKS) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) failNote("ready_rise");
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * FRAME_CLKS) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  task automatic checkIdleQuiet(input string name);
    int highs;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bclk || dac_dat) highs++;
    end
    checkOutput(name, highs, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int toggles;
    logic last_mclk;

    repeat (5) @(negedge clk);
    checkOutput("rst_bclk", {31'd0, bclk}, 0);
    checkOutput("rst_dat", {31'd0, dac_dat}, 0);
    checkOutput("rst_lrck", {31'd0, dac_lr_ck}, 0);
    checkOutput("rst_ready", {31'd0, s_ready}, 0);
    checkOutput("rst_underrun", {31'd0, underrun}, 0);

    mode = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, s_ready}, 1);
    checkOutput("idle_lrck_lj", {31'd0, dac_lr_ck}, 0);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_lrck_i2s", {31'd0, dac_lr_ck}, 1);
    mode = 1'b1;
    repeat (2) @(negedge clk);

    // Left-justified stream with back-pressure over eight frames
    applyStimulus(16'h8001, 16'h7FFE);
    @(negedge clk);
    checkOutput("ready_low_full", {31'd0, s_ready}, 0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(16'h1234, 16'h1000 + 16'(i));
    for (int k = 2; k < 8; k++)
      checkOutput("accept_spacing", accept_cycles[k] - accept_cycles[k-1], FRAME_CLKS);

    // Starvation: two underrun pulses one frame apart
    base = underrun_cycles.size();
    for (int w = 0; w < 4 * FRAME_CLKS && underrun_cycles.size() < base + 2; w++) @(negedge clk);
    if (underrun_cycles.size() < base + 2) failNote("underrun_pair");
    else checkOutput("underrun_spacing", underrun_cycles[base+1] - underrun_cycles[base], FRAME_CLKS);
    checkOutput("lj_drained", exp_q.size(), 0);

    // en dropped mid left slot: the frame still completes, then idle
    applyStimulus(16'hC3A5, 16'h5A3C);
    waitReady();
    waitLeftStart();
    repeat (128) @(negedge clk);
    en = 1'b0;
    waitDrain();
    repeat (300) @(negedge clk);
    checkIdleQuiet("idle_after_en_low");
    checkOutput("starve_zero_frames", {31'd0, zero_frames >= 2}, 1);

    // I2S stream
    mode = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(16'h8001, 16'h7FFE);
    en = 1'b1;
    applyStimulus(16'hFEDC, 16'h0123);
    waitDrain();
    en = 1'b0;
    repeat (400) @(negedge clk);
    checkIdleQuiet("idle_after_i2s");

    toggles = 0;
    last_mclk = mclk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mclk !== last_mclk) toggles++;
      last_mclk = mclk;
    end
`ifdef AUDIO_TX_MCLK_EN
    checkOutput("mclk_toggles", {31'd0, (toggles >= 19 && toggles <= 21)}, 1);
`else
    checkOutput("mclk_tied", toggles + {31'd0, mclk}, 0);
`endif

    // Asynchronous reset mid-frame discards the frame and the held pair
    mode = 1'b1;
    en = 1'b1;
    applyStimulus(16'h0A0A, 16'hB0B0);
    waitReady();
    applyStimulus(16'h1111, 16'h2222);
    waitLeftStart();
    repeat (100) @(negedge clk);
    #1;
    reset = 1'b0;
    en = 1'b0;
    #1;
    checkOutput("async_bclk", {31'd0, bclk}, 0);
    checkOutput("async_dat", {31'd0, dac_dat}, 0);
    checkOutput("async_lrck", {31'd0, dac_lr_ck}, 0);
    checkOutput("async_ready", {31'd0, s_ready}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_mid_rst", {31'd0, s_ready}, 1);
    applyStimulus(16'h6789, 16'h4321);
    en = 1'b1;
    waitDrain();
    en = 1'b0;
    repeat (400) @(negedge clk);
    checkOutput("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
